// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// timer_counter : memory-mapped down-counting timer, one-shot or auto-reload IRQ
// Revision 1.0
// ============================================================================
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0]  c_addr_ctrl   = 2'd0;
    localparam logic [1:0]  c_addr_preset = 2'd1;
    localparam logic [1:0]  c_addr_count  = 2'd2;
    localparam logic [1:0]  c_mode_reload = 2'd1;
    localparam logic [31:0] c_one         = 32'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pending;
    logic        r_irq;

    state_t      w_state_nxt;
    logic        w_en_nxt;
    logic [1:0]  w_mode_nxt;
    logic        w_im_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;
    logic        w_pending_nxt;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto_reload;

    assign w_wr_ctrl     = we && (addr == c_addr_ctrl);
    assign w_wr_preset   = we && (addr == c_addr_preset);
    assign w_auto_reload = (r_mode == c_mode_reload);

    always_comb begin
        w_state_nxt   = r_state;
        w_en_nxt      = r_en;
        w_mode_nxt    = r_mode;
        w_im_nxt      = r_im;
        w_preset_nxt  = r_preset;
        w_count_nxt   = r_count;
        w_pending_nxt = r_pending;

        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count <= c_one) begin
                    // PRESET of 0 lands here too, so it behaves like 1
                    w_count_nxt   = 32'd0;
                    w_pending_nxt = 1'b1;
                    w_state_nxt   = S_INT;
                end else begin
                    w_count_nxt = r_count - c_one;
                end
            end
            S_INT: begin
                if (w_auto_reload) begin
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = S_LOAD;
                end else begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Bus writes are applied last so they win over the FSM update
        if (w_wr_ctrl) begin
            w_en_nxt      = wdata[0];
            w_mode_nxt    = wdata[2:1];
            w_im_nxt      = wdata[3];
            w_pending_nxt = 1'b0;
            if (!wdata[0]) begin
                w_state_nxt = S_IDLE;
                w_count_nxt = r_count;
            end
        end

        if (w_wr_preset) begin
            w_preset_nxt  = wdata;
            w_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'd0;
            r_im      <= 1'b0;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_en      <= w_en_nxt;
            r_mode    <= w_mode_nxt;
            r_im      <= w_im_nxt;
            r_preset  <= w_preset_nxt;
            r_count   <= w_count_nxt;
            r_pending <= w_pending_nxt;
            r_irq     <= w_pending_nxt & w_im_nxt;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            c_addr_ctrl:   rdata = {28'd0, r_im, r_mode, r_en};
            c_addr_preset: rdata = r_preset;
            c_addr_count:  rdata = r_count;
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable timer/counter that sits on the CPU's peripheral bus and is the upstream source of the CPU `interrupt` input. Software programs a preset value and a mode through three 32-bit registers. The block counts down to zero and raises an interrupt request, either once (one-shot) or periodically (auto-reload). Its `irq` output connects directly to the CPU's interrupt pin, either alone or through the interrupt OR-tree.

## Interface
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately while low.
- `addr` input 2: word offset (bus address bits [3:2]). 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `we` input 1: write strobe; the write is sampled on the rising edge.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read data for `addr`.
- `irq` output 1: interrupt request to the CPU. `irq` = pending & CTRL.IM.

## Operation
- **CTRL register**
  - [0] EN: counting enable.
  - [2:1] MODE: 0 = one-shot; 1 = auto-reload; 2 and 3 behave as mode 0.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read as 0.
- **PRESET register:** 32-bit, fully R/W.
- **COUNT register:** read-only; writes are ignored. Offset 3 reads 0; writes to it are ignored.
- **Write side effect:** any write to CTRL or PRESET clears pending.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and hold COUNT.
    - Else if COUNT <= 1, set COUNT <= 0, set pending <= 1, and go to INT.
    - Else COUNT <= COUNT-1.
  - INT, mode 0: hardware clears EN and the FSM goes to IDLE. Pending stays set until software writes CTRL or PRESET.
  - INT, mode 1: go to LOAD. Pending clears on the next edge, so `irq` is a 1-cycle pulse per period.
- **Priority:** a bus write in the same cycle as an FSM update wins for the register it targets.
  - A CTRL write with EN=0 in any state sends the FSM to IDLE on that edge.
  - A CTRL write with EN=1 during INT in mode 0 keeps EN=1; the FSM still goes to IDLE and re-enters LOAD on the following edge.
- **PRESET writes during CNT:** do not affect the running COUNT. The new value is used at the next LOAD.
- **Arithmetic:** unsigned 32-bit. The decrement never wraps because COUNT <= 1 terminates the count. PRESET = 0 behaves as PRESET = 1.

## Timing
- **Reset values:** CTRL = 0, PRESET = 0, COUNT = 0, pending = 0, state = IDLE, `irq` = 0. `rdata` is 0 for all offsets while in reset.
- **Reset mid-operation:** asserting `reset` in any state forces the values above asynchronously. After release, nothing counts until software sets EN.
- **Edge numbering:** the edge that writes CTRL.EN=1 from IDLE is E0.
  - LOAD is entered at E1.
  - COUNT = N after E2.
  - COUNT = 1 after E(N+1).
  - INT is entered and `irq` rises after E(N+2), for N >= 1.
  - Latency from the enabling write to `irq` is max(N,1)+2 edges.
- **Auto-reload period:** N+2 cycles between `irq` pulses.
- **`rdata`:** combinational from current registers and `addr`; no read latency. A read in the same cycle as a write returns the pre-write value.

## Test plan
- **Reset:** hold `reset`=0 mid-count (PRESET=10, mode 0, EN=1) -> COUNT, CTRL and `irq` are 0 immediately. After release, COUNT stays 0 for 20 cycles.
- **One-shot:** PRESET=5, then CTRL=0b1001 (EN, mode 0, IM) -> `irq` rises exactly 7 edges after the CTRL write and stays high. CTRL reads 0b1000 afterwards. Writing CTRL=0b1000 drops `irq` on that edge.
- **Auto-reload:** PRESET=3, CTRL=0b1011 -> first `irq` pulse 5 edges after the write, then 1-cycle pulses every 5 cycles for at least 4 periods. COUNT reads 3,2,1 between pulses.
- **Mask:** PRESET=4, CTRL=0b0001 -> `irq` stays 0. After completion, writing CTRL=0b1000 clears pending, so `irq` stays 0 (mask enabled but pending already cleared).
- **Disable/edge cases:**
  - EN cleared while COUNT=7 -> COUNT holds 7 and `irq` stays 0.
  - PRESET=0 with mode 0 -> `irq` 3 edges after enable.
  - Writing COUNT=0x1234 -> no effect.
  - Reading offset 3 -> 0.
- **Simultaneous:** in mode 1, write PRESET=9 during CNT -> the current period completes with the old PRESET and the next period is 11 cycles. CTRL write EN=0 on the INT edge -> FSM goes to IDLE with no further pulses.
